// File: rtl/oversample_filter_pkg.sv
// oversample_filter_pkg
//   Shared definitions for the boxcar oversampling stage that feeds the PID core:
//   FSM state encodings, default oversample limits and the os_mode clamp helper.
package oversample_filter_pkg;

   // Default width of the frontpanel os_mode field
   localparam int OS_W_OS   = 4;
   // Largest accepted log2 oversample ratio
   localparam int OS_MAX_OS = 8;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_EMIT  = 1'b1
   } state_e;

   // Limit a requested oversample exponent to the largest supported one
   function automatic logic [OS_W_OS-1:0] clamp_os(input logic [OS_W_OS-1:0] mode,
                                                   input logic [OS_W_OS-1:0] max_os);
      logic [OS_W_OS-1:0] res;
      if (mode > max_os) begin
         res = max_os;
      end else begin
         res = mode;
      end
      return res;
   endfunction

endpackage

// File: rtl/oversample_filter.sv
// oversample_filter
//   Boxcar averaging stage in front of the PID core. Sums 2^os unsigned ADC
//   samples and emits their floor mean as a single valid-qualified word.
//   os is latched from the frontpanel with the update_en/update pulse pair.
// Ports
//   clk_in          system clock
//   reset_in        synchronous active-high reset
//   data_in         unsigned ADC sample (W_IN)
//   data_valid_in   one-cycle sample strobe
//   os_mode_in      requested log2 oversample ratio (W_OS)
//   update_en_in    arms update_in
//   update_in       pulse: latch os_mode_in (clamped to MAX_OS)
//   data_out        averaged sample, zero-extended to W_OUT
//   data_valid_out  one-cycle strobe qualifying data_out
module oversample_filter
   import oversample_filter_pkg::*;
#(
   parameter int W_IN   = 16,
   parameter int W_OUT  = 18,
   parameter int W_OS   = OS_W_OS,
   parameter int MAX_OS = OS_MAX_OS
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic [W_IN-1:0]   data_in,
   input  logic              data_valid_in,
   input  logic [W_OS-1:0]   os_mode_in,
   input  logic              update_en_in,
   input  logic              update_in,
   output logic [W_OUT-1:0]  data_out,
   output logic              data_valid_out
);

   localparam int ACC_W = W_IN + MAX_OS;
   localparam int CNT_W = MAX_OS + 1;

   state_e             state_q, state_d;
   logic [W_OS-1:0]    os_q, os_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [W_OUT-1:0]   data_q, data_d;

   logic               latch_s;
   logic               last_s;
   logic [ACC_W-1:0]   sum_s;
   logic [CNT_W-1:0]   term_cnt_s;

   // Decode the update request, the running sum and the block-complete condition
   always_comb begin
      latch_s    = update_in & update_en_in;
      sum_s      = acc_q + ACC_W'(data_in);
      term_cnt_s = (CNT_W'(1) << os_q) - CNT_W'(1);
      last_s     = data_valid_in & (count_q == term_cnt_s);
   end

   // Datapath next state: update beats sample, so a sample in the update cycle is dropped
   always_comb begin
      os_d    = os_q;
      acc_d   = acc_q;
      count_d = count_q;
      data_d  = data_q;
      if (latch_s) begin
         os_d    = W_OS'(clamp_os(OS_W_OS'(os_mode_in), OS_W_OS'(MAX_OS)));
         acc_d   = '0;
         count_d = '0;
      end else if (data_valid_in) begin
         if (last_s) begin
            // Mean of 2^os samples; fits in W_IN bits so the upper output bits stay zero
            acc_d   = '0;
            count_d = '0;
            data_d  = W_OUT'(sum_s >> os_q);
         end else begin
            acc_d   = sum_s;
            count_d = count_q + CNT_W'(1);
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Datapath registers
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         os_q    <= '0;
         acc_q   <= '0;
         count_q <= '0;
         data_q  <= '0;
      end else begin
         os_q    <= os_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         data_q  <= data_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q <= ST_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: ST_EMIT lasts one cycle, but a sample accepted during it may
   // itself complete a block (os=0 back-to-back), which re-enters ST_EMIT
   always_comb begin
      state_d = ST_ACCUM;
      case (state_q)
         ST_ACCUM, ST_EMIT: begin
            if (latch_s) begin
               state_d = ST_ACCUM;
            end else if (last_s) begin
               state_d = ST_EMIT;
            end else begin
               state_d = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   // FSM outputs: the strobe is decoded straight from the state flop
   always_comb begin
      data_valid_out = (state_q == ST_EMIT);
      data_out       = data_q;
   end

endmodule
